// File: rtl/branch_redirect_gen.sv
// Fetch redirect producer: classifies branch resolutions, holds redirects until fetch unfreezes,
// drains stale wrong-path resolutions, and emits predictor updates. Optional macro: BRU_PERF_COUNTERS_EN.
module branch_redirect_gen #(
  parameter int WIDTH        = 31,
  parameter int ROB_BITS     = 4,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                freeze,
  input  logic [ROB_BITS-1:0] robHead,
  input  logic                resValid,
  input  logic [ROB_BITS-1:0] resTag,
  input  logic [WIDTH:0]      resPC,
  input  logic                resTaken,
  input  logic [WIDTH:0]      resTarget,
  input  logic                predTaken,
  input  logic [WIDTH:0]      predTarget,
  output logic                mispredict,
  output logic                misdirect,
  output logic [WIDTH:0]      targetAddress,
  output logic [ROB_BITS-1:0] flushTag,
  output logic                updValid,
  output logic [WIDTH:0]      updPC,
  output logic                updTaken,
  output logic [WIDTH:0]      updTarget
`ifdef BRU_PERF_COUNTERS_EN
  ,
  output logic [31:0]         resolvedCount,
  output logic [31:0]         mispredictCount,
  output logic [31:0]         misdirectCount
`endif
);

  // state     | meaning
  // S_IDLE    | no redirect outstanding, every resolution accepted
  // S_PENDING | redirect driven and held until a cycle with freeze=0
  // S_DRAIN   | redirect consumed; resolutions younger than flush_q are dropped
  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_DRAIN} state_t;

  localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  state_t              state, state_d;
  logic [CNT_W-1:0]    drain_cnt, drain_cnt_d;
  logic [ROB_BITS-1:0] flush_q;

  logic                wrong_dir, wrong_tgt, is_err;
  logic [WIDTH:0]      corr_pc;
  logic [ROB_BITS-1:0] age_res, age_flush;
  logic                older, not_younger;
  logic                take_err, accept, consume;

  always_comb begin
    wrong_dir   = resTaken != predTaken;
    wrong_tgt   = resTaken & predTaken & (resTarget != predTarget);
    is_err      = wrong_dir | wrong_tgt;
    corr_pc     = resTaken ? resTarget : resPC + (WIDTH+1)'(1);
    age_res     = resTag - robHead;
    age_flush   = flush_q - robHead;
    older       = age_res < age_flush;
    not_younger = age_res <= age_flush;

    take_err = 1'b0;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        accept   = resValid;
        take_err = resValid & is_err;
      end
      S_PENDING: begin
        take_err = resValid & is_err & older;
        accept   = is_err ? take_err : resValid;
      end
      S_DRAIN: begin
        take_err = resValid & is_err & older;
        accept   = is_err ? take_err : (resValid & not_younger);
      end
      default: begin
        accept   = 1'b0;
        take_err = 1'b0;
      end
    endcase

    consume     = (state == S_PENDING) & ~freeze;
    state_d     = state;
    drain_cnt_d = drain_cnt;
    if (take_err) begin
      state_d     = S_PENDING;
      drain_cnt_d = '0;
    end else if (consume) begin
      state_d     = S_DRAIN;
      drain_cnt_d = CNT_W'(FLUSH_CYCLES);
    end else if (state == S_DRAIN) begin
      drain_cnt_d = drain_cnt - CNT_W'(1);
      if (drain_cnt <= CNT_W'(1)) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_d;
      drain_cnt <= drain_cnt_d;
    end
  end

  // A newer, older-by-age error overrides the held redirect even on the consume edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict    <= 1'b0;
      misdirect     <= 1'b0;
      targetAddress <= '0;
      flushTag      <= '0;
      flush_q       <= '0;
    end else if (take_err) begin
      mispredict    <= wrong_dir;
      misdirect     <= wrong_tgt;
      targetAddress <= corr_pc;
      flushTag      <= resTag;
      flush_q       <= resTag;
    end else if (consume) begin
      mispredict    <= 1'b0;
      misdirect     <= 1'b0;
      targetAddress <= '0;
      flushTag      <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      updValid  <= 1'b0;
      updPC     <= '0;
      updTaken  <= 1'b0;
      updTarget <= '0;
    end else begin
      updValid <= accept;
      if (accept) begin
        updPC     <= resPC;
        updTaken  <= resTaken;
        updTarget <= resTarget;
      end
    end
  end

`ifdef BRU_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resolvedCount   <= '0;
      mispredictCount <= '0;
      misdirectCount  <= '0;
    end else begin
      if (accept && resolvedCount != 32'hFFFF_FFFF)
        resolvedCount <= resolvedCount + 32'd1;
      if (consume && mispredict && mispredictCount != 32'hFFFF_FFFF)
        mispredictCount <= mispredictCount + 32'd1;
      if (consume && misdirect && misdirectCount != 32'hFFFF_FFFF)
        misdirectCount <= misdirectCount + 32'd1;
    end
  end
`endif

endmodule
